// File: rtl/asyn_count.sv
// Ripple binary up counter built from a chain of toggle flip-flops.
// Stage 0 runs on clk; each higher stage is clocked by the complement of the stage below.

module asyn_count_tff (
  input  logic clk,
  input  logic rst_n,
  output logic q,
  output logic qbar
);

  logic r_q;

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= 1'b0;
    else        r_q <= ~r_q;
  end

  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

module asyn_count #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qbar
);

  logic [WIDTH-1:0] w_stage_clk;

  // A rising qbar is a falling q: the carry out of the lower stage.
  // Stages share the async reset, so edges produced by a reset-driven clear are ignored.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      assign w_stage_clk[i] = clk;
    end else begin : g_rest
      assign w_stage_clk[i] = Qbar[i-1];
    end

    asyn_count_tff u_tff (
      .clk   (w_stage_clk[i]),
      .rst_n (rst),
      .q     (Q[i]),
      .qbar  (Qbar[i])
    );
  end

endmodule

// File: tb/tb_asyn_count.sv
// Directed bench for asyn_count (WIDTH = 3): vector table plus reset corner sequences.

module tb_asyn_count;

  localparam int W = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] Q;
  logic [W-1:0] Qbar;

  int total = 0;
  int bad   = 0;

  asyn_count #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .Q    (Q),
    .Qbar (Qbar)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic [W-1:0] exp_q;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_both(input string name, input logic [W-1:0] exp);
    logic [W-1:0] exp_bar;
    exp_bar = ~exp;
    check({name, ".Q"}, Q, exp);
    check({name, ".Qbar"}, Qbar, exp_bar);
  endtask

  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 3'd0};
    vecs[1]  = '{1'b0, 3'd0};
    vecs[2]  = '{1'b0, 3'd0};
    vecs[3]  = '{1'b1, 3'd1};
    vecs[4]  = '{1'b1, 3'd2};
    vecs[5]  = '{1'b1, 3'd3};
    vecs[6]  = '{1'b1, 3'd4};
    vecs[7]  = '{1'b1, 3'd5};
    vecs[8]  = '{1'b1, 3'd6};
    vecs[9]  = '{1'b1, 3'd7};
    vecs[10] = '{1'b1, 3'd0};
    vecs[11] = '{1'b1, 3'd1};
    vecs[12] = '{1'b1, 3'd2};

    rst = 1'b0;
    #1;
    check_both("reset_initial", 3'd0);

    // Table: drive rst midway between edges, sample on the following falling edge.
    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      rst = vecs[i].rst;
      @(posedge clk);
      @(negedge clk);
      check_both($sformatf("vec%0d", i), vecs[i].exp_q);
    end

    // Reset asserted between edges at Q=5 clears without a clock.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_both("pre_mid_reset", 3'd5);
    rst = 1'b0;
    #1;
    check_both("mid_reset_async", 3'd0);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_both("after_mid_release", 3'd1);

    // Reset coincident with a rising edge at Q=3 wins.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_both("pre_edge_reset", 3'd3);
    @(posedge clk);
    rst = 1'b0;
    #1;
    check_both("edge_reset", 3'd0);
    @(negedge clk);
    check_both("edge_reset_hold", 3'd0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_both("after_edge_release", 3'd1);

    // 200 ns free run from a fresh reset: 20 increments.
    rst = 1'b0;
    #1;
    rst = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_both("run_200ns", 3'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/asyn_count.md
# asyn_count

Asynchronous (ripple) binary up counter built structurally from a chain of toggle flip-flops. Bit 0 is clocked by the system clock, and each higher bit is clocked by the stage below it. The counter provides true and complemented count outputs. It serves as a small free-running divider/counter leaf cell. The module is named `asyn_count`, with a default width of 3 bits.

## Interface
- `WIDTH`, default 3: number of counter stages; supported range 1..16.
- `clk`, input, 1: counter clock; stage 0 toggles on its rising edge.
- `rst`, input, 1: asynchronous, active-low reset; `rst` = 0 clears the count immediately.
- `Q`, output, WIDTH: current count value; `Q[0]` is the LSB.
- `Qbar`, output, WIDTH: bitwise complement of `Q`.

## Operation
- Structure:
  - WIDTH instances of one toggle flip-flop cell (ports: clock, active-low async reset, q, qbar).
  - No behavioural adder anywhere in the design.
- Stage clocking:
  - Stage 0 is clocked by the rising edge of `clk`.
  - Stage i (i ≥ 1) is clocked by the rising edge of `Qbar[i-1]`, i.e. the falling edge of `Q[i-1]`.
- Each stage inverts its `q` on every active edge of its own clock, so the count increments by 1 per rising `clk` edge.
- Output relation:
  - `Qbar` = ~`Q` at all times, including during reset.
  - Both are driven directly from flip-flop state.
- Reset:
  - While `rst` = 0, every stage is held at `q` = 0, so `Q` = 0 and `Qbar` = all ones.
  - Reset takes effect immediately, with no clock required.
  - Reset overrides any clock edge arriving while it is asserted.
- Release:
  - After `rst` rises, the first rising `clk` edge gives `Q` = 1.
  - The release itself does not change state.
- Wrap-around:
  - From 2^WIDTH−1 (7 for WIDTH = 3), the next `clk` edge gives 0.
  - All stages toggle in ripple order.
  - `Qbar` returns to all ones.
- Reset mid-count (e.g. at `Q` = 5): `Q` clears to 0 asynchronously. The falling `Q` bits must not be treated as clocks to higher stages, because those stages are held in reset.
- No enable, load or direction inputs. The count is strictly up and free-running.

## Timing
- Latency: `Q[0]` changes one flip-flop clock-to-q delay after a rising `clk` edge.
- Ripple: `Q[i]` settles i additional clock-to-q delays after `Q[0]`.
- Transient values:
  - Intermediate codes are legal while the ripple propagates.
  - Example: 3 → 2 → 0 → 4 on the 3→4 step.
  - Consumers sample `Q` only after the full ripple has settled.
- In zero-delay simulation, `Q` is fully settled within the same timestep as the `clk` edge.
- Stages may carry a per-stage `#` delay for visualisation only. Any such delay must be well below half the `clk` period; the bench uses a 10 ns period.
- Reset assertion is asynchronous: outputs clear one clock-to-q delay after `rst` falls.
- Reset deassertion is not synchronised internally. `rst` must rise at least one setup time away from a rising `clk` edge.

## Test plan
- Hold `rst` = 0 for 3 `clk` edges:
  - `Q` = 000 and `Qbar` = 111 throughout.
  - No change on any `clk` edge.
- Release `rst`, then apply 8 rising `clk` edges:
  - `Q` reads 1, 2, 3, 4, 5, 6, 7, 0 after each edge.
  - `Qbar` = ~`Q` at each sample.
- Wrap check:
  - At `Q` = 7, one `clk` edge gives `Q` = 0 and `Qbar` = 7.
  - The counter continues to 1 on the next edge.
- Assert `rst` = 0 midway between edges at `Q` = 5:
  - `Q` = 0 immediately, with no wait for `clk`.
  - After release, the next edge gives `Q` = 1.
- Pulse `rst` low coincident with a rising `clk` edge at `Q` = 3: `Q` = 0, and the reset wins.
- Run 200 ns with a 10 ns clock after release:
  - 20 increments.
  - Final `Q` = 20 mod 8 = 4.
